// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM request arbiter.
// State encoding, address widths and requester ids.
package sdram_pkg;

    localparam int ROW_W = 12;
    localparam int COL_W = 12;
    localparam int BA_W  = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACC  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

endpackage

// File: rtl/sdram_rr_pick.sv
// Two-way round-robin select.
// On contention the side named by ptr_i wins.
module sdram_rr_pick
    import sdram_pkg::*;
(
    input  logic req_a_i,
    input  logic req_b_i,
    input  logic ptr_i,
    output logic grant_o,
    output logic grant_valid_o
);

    // Pick the winner; a lone requester always wins.
    always_comb begin
        grant_valid_o = req_a_i | req_b_i;
        grant_o       = REQ_A;
        if (req_a_i && req_b_i) begin
            grant_o = ptr_i;
        end else if (req_b_i) begin
            grant_o = REQ_B;
        end
    end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Two-port arbiter/sequencer in front of the SDRAM driver.
// One active-low strobe per grant, address held until next grant.
module sdram_req_arbiter
    import sdram_pkg::*;
#(
    parameter int SETTLE_CYC     = 2,
    parameter int ACCEPT_TIMEOUT = 16
) (
    input  logic             SDRAM_CLK_IN,
    input  logic             reset,
    input  logic             req_a,
    input  logic             we_a,
    input  logic [ROW_W-1:0] row_a,
    input  logic [COL_W-1:0] col_a,
    input  logic [BA_W-1:0]  bank_a,
    input  logic             req_b,
    input  logic             we_b,
    input  logic [ROW_W-1:0] row_b,
    input  logic [COL_W-1:0] col_b,
    input  logic [BA_W-1:0]  bank_b,
    output logic             done_a,
    output logic             done_b,
    output logic             err,
    output logic             start_write,
    output logic             start_read,
    output logic [ROW_W-1:0] ADDR_ROW,
    output logic [COL_W-1:0] ADDR_COL,
    output logic [BA_W-1:0]  BANK,
    input  logic             process_flg
);

    localparam logic [3:0] SETTLE_MAX = 4'(SETTLE_CYC);
    localparam logic [7:0] TMO_MAX    = 8'(ACCEPT_TIMEOUT);

    state_t           state_q, state_d;
    logic [3:0]       settle_q, settle_d;
    logic [7:0]       tmo_q, tmo_d;
    req_id_t          ptr_q, ptr_d;
    req_id_t          gnt_q, gnt_d;
    logic             we_q, we_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [BA_W-1:0]  bank_q, bank_d;
    logic             sw_q, sw_d;
    logic             sr_q, sr_d;
    logic             da_q, da_d;
    logic             db_q, db_d;
    logic             err_q, err_d;

    logic             pick_w;
    logic             pick_vld;
    req_id_t          pick_id;

    sdram_rr_pick u_pick (
        .req_a_i       (req_a),
        .req_b_i       (req_b),
        .ptr_i         (ptr_q),
        .grant_o       (pick_w),
        .grant_valid_o (pick_vld)
    );

    assign pick_id = req_id_t'(pick_w);

    // Next-state, counters and registered strobes/pulses.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        tmo_d    = tmo_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        we_d     = we_q;
        row_d    = row_q;
        col_d    = col_q;
        bank_d   = bank_q;
        sw_d     = 1'b1;
        sr_d     = 1'b1;
        da_d     = 1'b0;
        db_d     = 1'b0;
        err_d    = err_q;

        if (process_flg) begin
            settle_d = 4'd0;
        end else if (settle_q != SETTLE_MAX) begin
            settle_d = settle_q + 4'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (settle_q == SETTLE_MAX && pick_vld) begin
                    state_d = ISSUE;
                    gnt_d   = pick_id;
                    ptr_d   = (pick_id == REQ_A) ? REQ_B : REQ_A;
                    if (pick_id == REQ_B) begin
                        row_d  = row_b;
                        col_d  = col_b;
                        bank_d = bank_b;
                        we_d   = we_b;
                    end else begin
                        row_d  = row_a;
                        col_d  = col_a;
                        bank_d = bank_a;
                        we_d   = we_a;
                    end
                    // strobe is low during the ISSUE cycle
                    sw_d = ~we_d;
                    sr_d = we_d;
                end
            end
            ISSUE: begin
                tmo_d   = 8'd0;
                state_d = WAIT_ACC;
            end
            WAIT_ACC: begin
                if (process_flg) begin
                    state_d = WAIT_DONE;
                end else begin
                    if (tmo_q != TMO_MAX) begin
                        tmo_d = tmo_q + 8'd1;
                    end
                    if (tmo_d == TMO_MAX) begin
                        err_d   = 1'b1;
                        da_d    = (gnt_q == REQ_A);
                        db_d    = (gnt_q == REQ_B);
                        state_d = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!process_flg) begin
                    da_d     = (gnt_q == REQ_A);
                    db_d     = (gnt_q == REQ_B);
                    settle_d = 4'd0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge SDRAM_CLK_IN) begin
        if (reset) begin
            state_q  <= IDLE;
            settle_q <= 4'd0;
            tmo_q    <= 8'd0;
            ptr_q    <= REQ_A;
            gnt_q    <= REQ_A;
            we_q     <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            bank_q   <= '0;
            sw_q     <= 1'b1;
            sr_q     <= 1'b1;
            da_q     <= 1'b0;
            db_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            row_q    <= row_d;
            col_q    <= col_d;
            bank_q   <= bank_d;
            sw_q     <= sw_d;
            sr_q     <= sr_d;
            da_q     <= da_d;
            db_q     <= db_d;
            err_q    <= err_d;
        end
    end

    assign start_write = sw_q;
    assign start_read  = sr_q;
    assign done_a      = da_q;
    assign done_b      = db_q;
    assign err         = err_q;
    assign ADDR_ROW    = row_q;
    assign ADDR_COL    = col_q;
    assign BANK        = bank_q;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Scoreboard bench for sdram_req_arbiter.
// Directed requests against a small driver model.
module tb_sdram_req_arbiter;

    localparam int SETTLE_CYC = 2;

    typedef struct packed {
        logic        we;
        logic [11:0] row;
        logic [11:0] col;
        logic [1:0]  bank;
    } txn_t;

    logic clk = 1'b0;
    logic reset;
    logic req_a, we_a, req_b, we_b;
    logic [11:0] row_a, col_a, row_b, col_b;
    logic [1:0] bank_a, bank_b;
    logic done_a, done_b, err;
    logic start_write, start_read;
    logic [11:0] ADDR_ROW, ADDR_COL;
    logic [1:0] BANK;
    logic process_flg;
    logic init_flg, drv_flg;

    int drv_busy = 8;
    bit drv_noacc = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int low_run = 0;
    int strobe_cyc = 0;
    int done_cyc = 0;
    int fall_cyc = 0;

    txn_t exp_q[$];
    bit   done_q[$];

    assign process_flg = init_flg | drv_flg;

    always #5 clk = ~clk;

    sdram_req_arbiter #(
        .SETTLE_CYC     (2),
        .ACCEPT_TIMEOUT (16)
    ) dut (
        .SDRAM_CLK_IN (clk),
        .reset        (reset),
        .req_a        (req_a),
        .we_a         (we_a),
        .row_a        (row_a),
        .col_a        (col_a),
        .bank_a       (bank_a),
        .req_b        (req_b),
        .we_b         (we_b),
        .row_b        (row_b),
        .col_b        (col_b),
        .bank_b       (bank_b),
        .done_a       (done_a),
        .done_b       (done_b),
        .err          (err),
        .start_write  (start_write),
        .start_read   (start_read),
        .ADDR_ROW     (ADDR_ROW),
        .ADDR_COL     (ADDR_COL),
        .BANK         (BANK),
        .process_flg  (process_flg)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t",
                     name, got, exp, $time);
        end
    endtask

    // Driver model: accept a strobe one cycle later, stay busy drv_busy cycles.
    initial begin
        drv_flg = 1'b0;
        forever begin
            @(negedge clk);
            if (!drv_noacc && (!start_write || !start_read)) begin
                @(negedge clk);
                drv_flg = 1'b1;
                repeat (drv_busy) @(negedge clk);
                drv_flg = 1'b0;
            end
        end
    end

    // Monitor: pop expectations whenever a strobe or done appears.
    always @(posedge clk) begin
        txn_t t;
        bit id;
        cyc++;
        #1;
        if (process_flg) low_run = 0;
        else low_run++;
        if (!start_write || !start_read) begin
            strobe_cyc = cyc;
            chk("strobe_onehot", int'(!start_write && !start_read), 0);
            chk("settle_gap", int'(low_run >= SETTLE_CYC), 1);
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                t = exp_q.pop_front();
                chk("strobe_we", int'(!start_write), int'(t.we));
                chk("addr_row", int'(ADDR_ROW), int'(t.row));
                chk("addr_col", int'(ADDR_COL), int'(t.col));
                chk("bank", int'(BANK), int'(t.bank));
            end
        end
        if (done_a || done_b) begin
            done_cyc = cyc;
            chk("done_onehot", int'(done_a && done_b), 0);
            if (done_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                id = done_q.pop_front();
                chk("done_id", int'(done_b), int'(id));
            end
        end
    end

    task automatic wait_done(input bit id, input int max, input string nm);
        bit seen = 1'b0;
        for (int n = 0; n < max && !seen; n++) begin
            @(posedge clk);
            #1;
            if (id ? done_b : done_a) seen = 1'b1;
        end
        @(negedge clk);
        chk({nm, "_done_seen"}, int'(seen), 1);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_sw"}, int'(start_write), 1);
        chk({nm, "_sr"}, int'(start_read), 1);
        chk({nm, "_da"}, int'(done_a), 0);
        chk({nm, "_db"}, int'(done_b), 0);
        chk({nm, "_err"}, int'(err), 0);
        chk({nm, "_row"}, int'(ADDR_ROW), 0);
        chk({nm, "_col"}, int'(ADDR_COL), 0);
        chk({nm, "_bank"}, int'(BANK), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic set_a(input logic w, input logic [11:0] r,
                         input logic [11:0] c, input logic [1:0] b);
        we_a = w; row_a = r; col_a = c; bank_a = b;
        exp_q.push_back('{w, r, c, b});
    endtask

    task automatic set_b(input logic w, input logic [11:0] r,
                         input logic [11:0] c, input logic [1:0] b);
        we_b = w; row_b = r; col_b = c; bank_b = b;
        exp_q.push_back('{w, r, c, b});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; init_flg = 1'b0;
        req_a = 0; we_a = 0; row_a = 0; col_a = 0; bank_a = 0;
        req_b = 0; we_b = 0; row_b = 0; col_b = 0; bank_b = 0;
        repeat (3) @(negedge clk);
        chk_reset("rst");
        reset = 1'b0;

        // 1: single write from A
        repeat (3) @(negedge clk);
        set_a(1'b1, 12'h123, 12'h045, 2'd2);
        done_q.push_back(1'b0);
        req_a = 1'b1;
        wait_done(1'b0, 100, "t1");
        req_a = 1'b0;
        chk("t1_latency", done_cyc - strobe_cyc, 10);
        row_a = 12'hFFF;
        @(negedge clk);
        chk("t1_row_hold", int'(ADDR_ROW), 'h123);
        chk("t1_err", int'(err), 0);

        // 2: both requesting, grants alternate A B A B
        do_reset();
        set_a(1'b1, 12'h011, 12'h0A1, 2'd0);
        set_b(1'b0, 12'h022, 12'h0B1, 2'd1);
        exp_q.push_back('{1'b0, 12'h033, 12'h0A2, 2'd2});
        exp_q.push_back('{1'b1, 12'h044, 12'h0B2, 2'd3});
        done_q.push_back(1'b0); done_q.push_back(1'b1);
        done_q.push_back(1'b0); done_q.push_back(1'b1);
        req_a = 1'b1; req_b = 1'b1;
        fork
            begin
                wait_done(1'b0, 200, "t2_a1");
                we_a = 1'b0; row_a = 12'h033;
                col_a = 12'h0A2; bank_a = 2'd2;
                wait_done(1'b0, 200, "t2_a2");
                req_a = 1'b0;
            end
            begin
                wait_done(1'b1, 200, "t2_b1");
                we_b = 1'b1; row_b = 12'h044;
                col_b = 12'h0B2; bank_b = 2'd3;
                wait_done(1'b1, 200, "t2_b2");
                req_b = 1'b0;
            end
        join

        // 3: driver init holds off a read from B
        do_reset();
        init_flg = 1'b1;
        repeat (2) @(negedge clk);
        set_b(1'b0, 12'h3C3, 12'h1E1, 2'd1);
        done_q.push_back(1'b1);
        req_b = 1'b1;
        repeat (500) @(negedge clk);
        chk("t3_no_strobe", exp_q.size(), 1);
        init_flg = 1'b0;
        fall_cyc = cyc;
        wait_done(1'b1, 100, "t3");
        req_b = 1'b0;
        chk("t3_issue_delay", strobe_cyc - fall_cyc, 3);
        chk("t3_err", int'(err), 0);

        // 4: driver never accepts, then a normal request
        drv_noacc = 1'b1;
        set_a(1'b0, 12'h0F0, 12'h00F, 2'd3);
        done_q.push_back(1'b0);
        req_a = 1'b1;
        wait_done(1'b0, 100, "t4_to");
        req_a = 1'b0;
        chk("t4_timeout_cyc", done_cyc - strobe_cyc, 17);
        chk("t4_err_set", int'(err), 1);
        drv_noacc = 1'b0;
        set_b(1'b1, 12'h555, 12'h2AA, 2'd0);
        done_q.push_back(1'b1);
        req_b = 1'b1;
        wait_done(1'b1, 100, "t4_next");
        req_b = 1'b0;
        chk("t4_err_sticky", int'(err), 1);

        // 5: long busy (merged refresh), no timeout
        do_reset();
        chk("t5_err_clr", int'(err), 0);
        drv_busy = 20;
        set_a(1'b1, 12'h7E7, 12'h101, 2'd1);
        done_q.push_back(1'b0);
        req_a = 1'b1;
        wait_done(1'b0, 100, "t5");
        req_a = 1'b0;
        chk("t5_latency", done_cyc - strobe_cyc, 22);
        chk("t5_err", int'(err), 0);
        drv_busy = 8;

        // 6: reset during WAIT_DONE
        repeat (4) @(negedge clk);
        set_a(1'b0, 12'h246, 12'h135, 2'd2);
        req_a = 1'b1;
        for (int n = 0; n < 50 && !process_flg; n++)
            @(negedge clk);
        chk("t6_busy_seen", int'(process_flg), 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        req_a = 1'b0;
        @(posedge clk);
        #1;
        chk_reset("t6");
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        set_a(1'b1, 12'h0AA, 12'h0A0, 2'd1);
        set_b(1'b1, 12'h0BB, 12'h0B0, 2'd2);
        done_q.push_back(1'b0); done_q.push_back(1'b1);
        req_a = 1'b1; req_b = 1'b1;
        wait_done(1'b0, 100, "t6_a");
        req_a = 1'b0;
        wait_done(1'b1, 100, "t6_b");
        req_b = 1'b0;

        repeat (10) @(negedge clk);
        chk("strobes_left", exp_q.size(), 0);
        chk("dones_left", done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
